// File: rtl/key_svc_pkg.sv
// -----------------------------------------------------------------------------
// key_svc_pkg
// Shared definitions for the key PIO servicer: FSM state encoding, PIO register
// addresses, the key event record and the Avalon-MM command bundle, together
// with the per-state bus command decoder.
// Optional feature macro used by the rest of the slice: KEY_SVC_TIMESTAMP_EN.
// -----------------------------------------------------------------------------
package key_svc_pkg;

    typedef enum logic [2:0] {
        ST_INIT_MASK,
        ST_INIT_CLR,
        ST_IDLE,
        ST_WR_MASK,
        ST_RD_CAP,
        ST_CLR_CAP,
        ST_RD_LVL,
        ST_PUSH
    } key_svc_state_e;

    localparam logic [1:0] KEY_ADDR_DATA = 2'd0;
    localparam logic [1:0] KEY_ADDR_MASK = 2'd2;
    localparam logic [1:0] KEY_ADDR_EDGE = 2'd3;

    // One queued key event (timestamp, when enabled, is appended above it).
    typedef struct packed {
        logic [3:0] edges;
        logic [3:0] level;
    } key_evt_t;

    typedef struct packed {
        logic [1:0]  address;
        logic        chipselect;
        logic        write_n;
        logic [31:0] writedata;
    } avm_cmd_t;

    localparam avm_cmd_t AVM_IDLE = '{
        address:    KEY_ADDR_DATA,
        chipselect: 1'b0,
        write_n:    1'b1,
        writedata:  32'h0
    };

    // Bus command presented while the FSM sits in state st.
    function automatic avm_cmd_t avm_cmd(key_svc_state_e st,
                                         logic [3:0]     init_mask,
                                         logic [3:0]     cfg_mask);
        avm_cmd_t c;
        c = AVM_IDLE;
        case (st)
            ST_INIT_MASK: c = '{KEY_ADDR_MASK, 1'b1, 1'b0, {28'h0, init_mask}};
            ST_INIT_CLR:  c = '{KEY_ADDR_EDGE, 1'b1, 1'b0, 32'hF};
            ST_WR_MASK:   c = '{KEY_ADDR_MASK, 1'b1, 1'b0, {28'h0, cfg_mask}};
            // Reads keep chipselect low; the PIO readdata path ignores it.
            ST_RD_CAP:    c.address = KEY_ADDR_EDGE;
            ST_CLR_CAP:   c = '{KEY_ADDR_EDGE, 1'b1, 1'b0, 32'hF};
            ST_RD_LVL:    c.address = KEY_ADDR_DATA;
            default:      c = AVM_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/key_svc_fifo.sv
// -----------------------------------------------------------------------------
// key_svc_fifo
// Synchronous FIFO for key events with occupancy count.
// Ports: clk, reset_n (async, active-low); push/din write side (ignored when
// full unless a pop happens in the same cycle); pop/dout read side (dout is the
// head entry, forced to zero while empty); empty, full, count status.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module key_svc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + (PTR_W + 1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (PTR_W + 1)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; emptiness comes from the count, and dout is
    // masked while empty so stale contents never reach the consumer.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/key_pio_servicer.sv
// -----------------------------------------------------------------------------
// key_pio_servicer
// Avalon-MM master that services a 4-bit key PIO: programs its irq mask, reacts
// to pio_irq by reading and clearing edge capture, samples the key levels and
// queues {edges, level} events for on-chip consumers as a valid/ready stream.
// Ports:
//   clk, reset_n            single clock, async active-low reset
//   avm_*                   master port to the PIO slave (registered outputs)
//   pio_irq                 PIO interrupt
//   cfg_mask / cfg_update   mask rewrite request (pulse; last value wins)
//   evt_valid/evt_ready     event stream handshake
//   evt_edges / evt_level   head event contents
//   evt_time                head capture timestamp (KEY_SVC_TIMESTAMP_EN only)
//   busy, fifo_level        FSM activity and queue occupancy
// Optional feature: define KEY_SVC_TIMESTAMP_EN to add a free-running TS_W-bit
// counter sampled at edge capture and carried with each event.
// -----------------------------------------------------------------------------
module key_pio_servicer
    import key_svc_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] INIT_MASK  = 4'hF,
    parameter int         TS_W       = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic [1:0]                    avm_address,
    output logic                          avm_chipselect,
    output logic                          avm_write_n,
    output logic [31:0]                   avm_writedata,
    input  logic [31:0]                   avm_readdata,
    input  logic                          pio_irq,
    input  logic [3:0]                    cfg_mask,
    input  logic                          cfg_update,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [3:0]                    evt_edges,
    output logic [3:0]                    evt_level,
`ifdef KEY_SVC_TIMESTAMP_EN
    output logic [TS_W-1:0]               evt_time,
`endif
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

`ifdef KEY_SVC_TIMESTAMP_EN
    localparam int EVT_W = $bits(key_evt_t) + TS_W;
`else
    localparam int EVT_W = $bits(key_evt_t);
    localparam int ts_w_unused = TS_W;
`endif

    key_svc_state_e state_q, state_d;
    avm_cmd_t       cmd_q, cmd_d;
    logic           started_q, started_d;
    logic           pending_q, pending_d;
    logic [3:0]     mask_q, mask_d;
    logic [3:0]     edges_q, edges_d;
    logic           busy_q, busy_d;

    logic             fifo_push, fifo_full, fifo_empty;
    logic [EVT_W-1:0] fifo_din, fifo_dout;
    key_evt_t         push_evt, head_evt;
    logic             readdata_unused;

    assign readdata_unused = ^avm_readdata[31:4];

    always_comb begin
        state_d   = state_q;
        started_d = 1'b1;
        pending_d = pending_q;
        mask_d    = mask_q;
        edges_d   = edges_q;

        if (cfg_update) begin
            pending_d = 1'b1;
            mask_d    = cfg_mask;
        end

        case (state_q)
            // Hold one cycle after reset release so the mask write is the
            // first bus action seen outside reset.
            ST_INIT_MASK: if (started_q) state_d = ST_INIT_CLR;
            ST_INIT_CLR:  state_d = ST_IDLE;
            ST_IDLE: begin
                if (pending_q)                   state_d = ST_WR_MASK;
                else if (pio_irq && !fifo_full)  state_d = ST_RD_CAP;
            end
            ST_WR_MASK: begin
                state_d = ST_IDLE;
                // A pulse landing on the write cycle stays pending for a rewrite.
                if (!cfg_update) pending_d = 1'b0;
            end
            ST_RD_CAP:  state_d = ST_CLR_CAP;
            ST_CLR_CAP: begin
                edges_d = avm_readdata[3:0];
                state_d = ST_RD_LVL;
            end
            ST_RD_LVL:  state_d = ST_PUSH;
            ST_PUSH:    state_d = ST_IDLE;
            default:    state_d = ST_INIT_MASK;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        // mask_d is used so a pulse in the deciding IDLE cycle is not lost.
        cmd_d  = avm_cmd(state_d, INIT_MASK, mask_d);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_INIT_MASK;
            cmd_q     <= AVM_IDLE;
            started_q <= 1'b0;
            pending_q <= 1'b0;
            mask_q    <= 4'h0;
            edges_q   <= 4'h0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            started_q <= started_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            edges_q   <= edges_d;
            busy_q    <= busy_d;
        end
    end

    // Level data is on readdata during PUSH; an all-zero edge read is spurious.
    assign push_evt  = '{edges: edges_q, level: avm_readdata[3:0]};
    assign fifo_push = (state_q == ST_PUSH) && (edges_q != 4'h0);

`ifdef KEY_SVC_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
    logic [TS_W-1:0] cap_ts_q, cap_ts_d;

    always_comb begin
        ts_d     = ts_q + TS_W'(1);
        cap_ts_d = (state_q == ST_CLR_CAP) ? ts_q : cap_ts_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q     <= '0;
            cap_ts_q <= '0;
        end else begin
            ts_q     <= ts_d;
            cap_ts_q <= cap_ts_d;
        end
    end

    assign fifo_din = {cap_ts_q, push_evt};
    assign evt_time = fifo_dout[EVT_W-1:$bits(key_evt_t)];
`else
    assign fifo_din = push_evt;
`endif

    key_svc_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     (fifo_din),
        .pop     (evt_ready),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_level)
    );

    assign head_evt  = fifo_dout[$bits(key_evt_t)-1:0];
    assign evt_valid = !fifo_empty;
    assign evt_edges = head_evt.edges;
    assign evt_level = head_evt.level;

    assign avm_address    = cmd_q.address;
    assign avm_chipselect = cmd_q.chipselect;
    assign avm_write_n    = cmd_q.write_n;
    assign avm_writedata  = cmd_q.writedata;
    assign busy           = busy_q;

endmodule

// File: tb/tb_key_pio_servicer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_key_pio_servicer
// Directed bench for key_pio_servicer with a small behavioural key PIO model
// (data / irq mask / edge capture, falling-edge detect, registered readdata).
// -----------------------------------------------------------------------------
module tb_key_pio_servicer;

    localparam int TS_W = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        pio_irq;
    logic [3:0]  cfg_mask = 4'h0;
    logic        cfg_update = 1'b0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [3:0]  evt_edges;
    logic [3:0]  evt_level;
`ifdef KEY_SVC_TIMESTAMP_EN
    logic [TS_W-1:0] evt_time;
`endif
    logic        busy;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_pio_servicer #(
        .FIFO_DEPTH (4),
        .INIT_MASK  (4'hF),
        .TS_W       (TS_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .pio_irq        (pio_irq),
        .cfg_mask       (cfg_mask),
        .cfg_update     (cfg_update),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_edges      (evt_edges),
        .evt_level      (evt_level),
`ifdef KEY_SVC_TIMESTAMP_EN
        .evt_time       (evt_time),
`endif
        .busy           (busy),
        .fifo_level     (fifo_level)
    );

    // ---------------- key PIO model ----------------
    logic [3:0]  key_in    = 4'hF;
    logic [3:0]  pio_prev  = 4'hF;
    logic [3:0]  pio_mask  = 4'h0;
    logic [3:0]  pio_edge  = 4'h0;
    logic [31:0] pio_rdata = 32'h0;
    logic        spur_irq  = 1'b0;
    int          clr_writes = 0;

    assign pio_irq      = (|(pio_edge & pio_mask)) | spur_irq;
    assign avm_readdata = pio_rdata;

    always @(posedge clk) begin
        pio_prev <= key_in;
        if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
            pio_mask <= avm_writedata[3:0];
        if (avm_chipselect && !avm_write_n && avm_address == 2'd3) begin
            pio_edge   <= pio_prev & ~key_in;
            clr_writes <= clr_writes + 1;
        end else begin
            pio_edge <= pio_edge | (pio_prev & ~key_in);
        end
        case (avm_address)
            2'd0:    pio_rdata <= {28'h0, key_in};
            2'd2:    pio_rdata <= {28'h0, pio_mask};
            2'd3:    pio_rdata <= {28'h0, pio_edge};
            default: pio_rdata <= 32'h0;
        endcase
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    // Waits for busy to rise, then counts the cycles it stays high.
    task automatic wait_service(input string tag, output int len);
        int n;
        n   = 0;
        len = 0;
        while (!busy && n < 30) begin step(); n++; end
        if (!busy) begin timeout(tag); return; end
        while (busy && len < 30) begin step(); len++; end
    endtask

    task automatic pop_check(input string tag, input logic [3:0] e, input logic [3:0] l);
        int n;
        n = 0;
        while (!evt_valid && n < 30) begin step(); n++; end
        if (!evt_valid) begin timeout(tag); return; end
        check({tag, "_edges"}, 32'(evt_edges), 32'(e));
        check({tag, "_level"}, 32'(evt_level), 32'(l));
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_addr"}, 32'(avm_address), 32'h0);
        check({tag, "_cs"},   32'(avm_chipselect), 32'h0);
        check({tag, "_wn"},   32'(avm_write_n), 32'h1);
        check({tag, "_wd"},   avm_writedata, 32'h0);
    endtask

    task automatic check_init_seq(input string tag);
        step();
        check({tag, "_c1_addr"}, 32'(avm_address), 32'h2);
        check({tag, "_c1_wr"},   32'({avm_chipselect, avm_write_n}), 32'h2);
        check({tag, "_c1_wd"},   avm_writedata, 32'hF);
        step();
        check({tag, "_c2_addr"}, 32'(avm_address), 32'h3);
        check({tag, "_c2_wr"},   32'({avm_chipselect, avm_write_n}), 32'h2);
        check({tag, "_c2_wd"},   avm_writedata, 32'hF);
        check({tag, "_c2_busy"}, 32'(busy), 32'h1);
        step();
        check({tag, "_c3_busy"}, 32'(busy), 32'h0);
        check_idle_bus({tag, "_c3"});
        check({tag, "_pio_mask"}, 32'(pio_mask), 32'hF);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int len;
        int n;
        int clr0;

        // Reset values and init sequence.
        repeat (3) @(posedge clk);
        #1;
        check_idle_bus("rst");
        check("rst_busy",  32'(busy), 32'h1);
        check("rst_valid", 32'(evt_valid), 32'h0);
        check("rst_edges", 32'(evt_edges), 32'h0);
        check("rst_level", 32'(evt_level), 32'h0);
        check("rst_level_cnt", 32'(fifo_level), 32'h0);
        reset_n = 1'b1;
        check_init_seq("init");

        // Key1 press: one event, edge register cleared.
        key_in[1] = 1'b0;
        wait_service("key1_seq", len);
        check("key1_seq_len", 32'(len), 32'd4);
        check("key1_valid",   32'(evt_valid), 32'h1);
        check("key1_edges",   32'(evt_edges), 32'h2);
        check("key1_level",   32'(evt_level), 32'hD);
        check("key1_pio_edge", 32'(pio_edge), 32'h0);
        check("key1_cnt",     32'(fifo_level), 32'h1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("key1_popped_valid", 32'(evt_valid), 32'h0);
        check("key1_popped_cnt",   32'(fifo_level), 32'h0);
        key_in = 4'hF;
        repeat (3) step();

        // Config update racing a key0 interrupt: mask write goes first.
        key_in[0]  = 1'b0;
        cfg_mask   = 4'h1;
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        check("cfg_irq_high", 32'(pio_irq), 32'h1);
        check("cfg_busy0",    32'(busy), 32'h0);
        step();
        check("cfg_wr_addr", 32'(avm_address), 32'h2);
        check("cfg_wr_wr",   32'({avm_chipselect, avm_write_n}), 32'h2);
        check("cfg_wr_wd",   avm_writedata, 32'h1);
        step();
        check("cfg_back_idle", 32'(busy), 32'h0);
        step();
        check("cfg_rdcap_addr", 32'(avm_address), 32'h3);
        check("cfg_rdcap_rd",   32'({avm_chipselect, avm_write_n}), 32'h1);
        pop_check("cfg_evt", 4'h1, 4'hE);
        check("cfg_pio_mask", 32'(pio_mask), 32'h1);
        key_in = 4'hF;
        repeat (2) step();
        key_in[2] = 1'b0;
        repeat (8) step();
        check("masked_irq",   32'(pio_irq), 32'h0);
        check("masked_busy",  32'(busy), 32'h0);
        check("masked_cnt",   32'(fifo_level), 32'h0);
        key_in = 4'hF;
        // Unmasking exposes the still-captured key2 edge.
        cfg_mask   = 4'hF;
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        pop_check("unmask_evt", 4'h4, 4'hF);
        check("unmask_pio_mask", 32'(pio_mask), 32'hF);
        repeat (3) step();

        // FIFO full: four queued presses, then merged edges while full.
        for (int k = 0; k < 4; k++) begin
            key_in[k] = 1'b0;
            wait_service("fill_seq", len);
            key_in = 4'hF;
            repeat (2) step();
        end
        check("full_cnt",   32'(fifo_level), 32'h4);
        check("full_valid", 32'(evt_valid), 32'h1);
        key_in[1] = 1'b0;
        repeat (10) step();
        check("full_no_service", 32'(busy), 32'h0);
        check("full_irq_high",   32'(pio_irq), 32'h1);
        check("full_cnt_hold",   32'(fifo_level), 32'h4);
        key_in = 4'hF;
        repeat (2) step();
        key_in[2] = 1'b0;
        repeat (2) step();
        key_in = 4'hF;
        repeat (2) step();
        check("full_head_stable", 32'(evt_edges), 32'h1);
        pop_check("full_e0", 4'h1, 4'hE);
        pop_check("full_e1", 4'h2, 4'hD);
        pop_check("full_e2", 4'h4, 4'hB);
        pop_check("full_e3", 4'h8, 4'h7);
        pop_check("full_merged", 4'h6, 4'hF);
        check("drained_cnt", 32'(fifo_level), 32'h0);
        repeat (3) step();

        // Spurious interrupt: full 4-cycle sequence, no push.
        clr0     = clr_writes;
        spur_irq = 1'b1;
        step();
        spur_irq = 1'b0;
        wait_service("spur_seq", len);
        check("spur_seq_len", 32'(len), 32'd4);
        check("spur_cnt",     32'(fifo_level), 32'h0);
        check("spur_valid",   32'(evt_valid), 32'h0);
        check("spur_clr",     32'(clr_writes), 32'(clr0 + 1));

        // Reset in CLR_CAP with a queued event and a non-default mask.
        cfg_mask   = 4'h5;
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        repeat (3) step();
        check("pre_rst_mask", 32'(pio_mask), 32'h5);
        key_in[0] = 1'b0;
        wait_service("pre_rst_seq", len);
        key_in = 4'hF;
        repeat (2) step();
        check("pre_rst_cnt", 32'(fifo_level), 32'h1);
        key_in[2] = 1'b0;
        n = 0;
        while (!(avm_chipselect && !avm_write_n && avm_address == 2'd3) && n < 30) begin
            step();
            n++;
        end
        if (n == 30) timeout("rst_wait_clr");
        reset_n = 1'b0;
        #1;
        check_idle_bus("midrst");
        check("midrst_valid", 32'(evt_valid), 32'h0);
        check("midrst_cnt",   32'(fifo_level), 32'h0);
        check("midrst_busy",  32'(busy), 32'h1);
        key_in = 4'hF;
        repeat (2) step();
        reset_n = 1'b1;
        check_init_seq("reinit");
        check("reinit_edge_cleared", 32'(pio_edge), 32'h0);
        repeat (6) step();
        check("reinit_cnt",   32'(fifo_level), 32'h0);
        check("reinit_valid", 32'(evt_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
